// File: rtl/paranut_wb_pkg.sv
// ============================================================================
// Module  : paranut_wb_pkg
// Brief   : Shared Wishbone B3 constants and the arbiter FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package paranut_wb_pkg;

  // Cycle type identifiers
  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] CONST   = 3'b001;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

  // Burst type extensions
  localparam logic [1:0] LINEAR  = 2'b00;
  localparam logic [1:0] WRAP4   = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module  : rr_priority_pick
// Brief   : Combinational round-robin pick: first requester after lp, wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_lp,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  // Outer loop selects the rotation for the current lp so that every
  // request index is a constant; inner loop runs backwards so the
  // closest requester after lp is the last (winning) assignment.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (i_lp == IW'(j)) begin
        for (int i = N_REQ; i >= 1; i--) begin
          if (i_req[(j + i) % N_REQ]) begin
            o_idx   = IW'((j + i) % N_REQ);
            o_valid = 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_master_arbiter.sv
// ============================================================================
// Module  : wb_master_arbiter
// Brief   : Round-robin arbiter sharing one Wishbone B3 master port among
//           N_REQ requesters; ownership is held until the owner drops cyc.
//           Optional slave watchdog: define WB_MASTER_ARBITER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_arbiter
  import paranut_wb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic [N_REQ-1:0]   req_cyc_i,
  input  logic [N_REQ-1:0]   req_stb_i,
  input  logic [N_REQ-1:0]   req_we_i,
  input  logic [4*N_REQ-1:0] req_sel_i,
  input  logic [AW*N_REQ-1:0] req_adr_i,
  input  logic [DW*N_REQ-1:0] req_dat_i,
  input  logic [3*N_REQ-1:0] req_cti_i,
  input  logic [2*N_REQ-1:0] req_bte_i,
  output logic [N_REQ-1:0]   req_ack_o,
  output logic [N_REQ-1:0]   req_err_o,
  output logic [N_REQ-1:0]   req_rty_o,
  output logic [DW-1:0]      req_dat_o,
  output logic [N_REQ-1:0]   grant_o,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  input  logic               wb_rty_i,
  input  logic [DW-1:0]      wb_dat_i,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [3:0]         wb_sel_o,
  output logic [AW-1:0]      wb_adr_o,
  output logic [DW-1:0]      wb_dat_o,
  output logic [2:0]         wb_cti_o,
  output logic [1:0]         wb_bte_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_g, w_g_nxt;
  logic [IW-1:0] r_lp, w_lp_nxt;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_valid;
  logic          w_grant;

  logic [N_REQ-1:0] w_own_onehot;
  logic             w_own_cyc, w_own_stb, w_own_we;
  logic [3:0]       w_own_sel;
  logic [AW-1:0]    w_own_adr;
  logic [DW-1:0]    w_own_dat;
  logic [2:0]       w_own_cti;
  logic [1:0]       w_own_bte;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req   (req_cyc_i),
    .i_lp    (r_lp),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_grant   = (r_state == IDLE) && !stall_i && w_pick_valid;
  assign req_dat_o = wb_dat_i;

  // Select the current owner's bus signals
  always_comb begin
    w_own_onehot = '0;
    w_own_cyc    = 1'b0;
    w_own_stb    = 1'b0;
    w_own_we     = 1'b0;
    w_own_sel    = '0;
    w_own_adr    = '0;
    w_own_dat    = '0;
    w_own_cti    = '0;
    w_own_bte    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_g == IW'(k)) begin
        w_own_onehot[k] = 1'b1;
        w_own_cyc       = req_cyc_i[k];
        w_own_stb       = req_stb_i[k];
        w_own_we        = req_we_i[k];
        w_own_sel       = req_sel_i[4*k +: 4];
        w_own_adr       = req_adr_i[AW*k +: AW];
        w_own_dat       = req_dat_i[DW*k +: DW];
        w_own_cti       = req_cti_i[3*k +: 3];
        w_own_bte       = req_bte_i[2*k +: 2];
      end
    end
  end

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_grant || wb_ack_i || wb_err_i || wb_rty_i) begin
      r_cnt <= '0;
    end else if ((r_state == BUSY) && w_own_stb) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_timeout = (r_state == BUSY) && (r_cnt == CW'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_lp    <= IW'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_lp    <= w_lp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_lp_nxt    = r_lp;
    grant_o     = '0;
    req_ack_o   = '0;
    req_err_o   = '0;
    req_rty_o   = '0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_sel_o    = '0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    wb_cti_o    = '0;
    wb_bte_o    = '0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = BUSY;
          w_g_nxt     = w_pick_idx;
        end
      end
      BUSY: begin
        grant_o   = w_own_onehot;
        req_ack_o = w_own_onehot & {N_REQ{wb_ack_i}};
        req_err_o = w_own_onehot & {N_REQ{wb_err_i}};
        req_rty_o = w_own_onehot & {N_REQ{wb_rty_i}};
        wb_cyc_o  = w_own_cyc;
        wb_stb_o  = w_own_stb;
        wb_we_o   = w_own_we;
        wb_sel_o  = w_own_sel;
        wb_adr_o  = w_own_adr;
        wb_dat_o  = w_own_dat;
        wb_cti_o  = w_own_cti;
        wb_bte_o  = w_own_bte;
        if (!w_own_cyc) begin
          w_state_nxt = IDLE;
          w_lp_nxt    = r_g;
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
        end else if (w_timeout) begin
          // Kill the stuck cycle and report an error to the owner only
          wb_cyc_o    = 1'b0;
          wb_stb_o    = 1'b0;
          req_ack_o   = '0;
          req_rty_o   = '0;
          req_err_o   = w_own_onehot;
          w_state_nxt = ABORT;
`endif
        end
      end
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
      ABORT: begin
        if (!w_own_cyc) begin
          w_state_nxt = IDLE;
          w_lp_nxt    = r_g;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
// ============================================================================
// Module  : tb_wb_master_arbiter
// Brief   : Directed self-checking bench for wb_master_arbiter (N_REQ=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_master_arbiter;
  import paranut_wb_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [N-1:0]    req_cyc, req_stb, req_we;
  logic [4*N-1:0]  req_sel;
  logic [AW*N-1:0] req_adr;
  logic [DW*N-1:0] req_dat;
  logic [3*N-1:0]  req_cti;
  logic [2*N-1:0]  req_bte;
  logic [N-1:0]    req_ack, req_err, req_rty;
  logic [DW-1:0]   req_dat_o;
  logic [N-1:0]    grant;
  logic            wb_ack, wb_err, wb_rty;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_cyc, wb_stb, wb_we;
  logic [3:0]      wb_sel;
  logic [AW-1:0]   wb_adr;
  logic [DW-1:0]   wb_dat_o;
  logic [2:0]      wb_cti;
  logic [1:0]      wb_bte;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [2:0]  beat_cti  [4] = '{INCR, INCR, INCR, EOB};
  logic [31:0] beat_adr  [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .N_REQ   (N),
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .stall_i   (stall),
    .req_cyc_i (req_cyc),
    .req_stb_i (req_stb),
    .req_we_i  (req_we),
    .req_sel_i (req_sel),
    .req_adr_i (req_adr),
    .req_dat_i (req_dat),
    .req_cti_i (req_cti),
    .req_bte_i (req_bte),
    .req_ack_o (req_ack),
    .req_err_o (req_err),
    .req_rty_o (req_rty),
    .req_dat_o (req_dat_o),
    .grant_o   (grant),
    .wb_ack_i  (wb_ack),
    .wb_err_i  (wb_err),
    .wb_rty_i  (wb_rty),
    .wb_dat_i  (wb_dat_i),
    .wb_cyc_o  (wb_cyc),
    .wb_stb_o  (wb_stb),
    .wb_we_o   (wb_we),
    .wb_sel_o  (wb_sel),
    .wb_adr_o  (wb_adr),
    .wb_dat_o  (wb_dat_o),
    .wb_cti_o  (wb_cti),
    .wb_bte_o  (wb_bte)
  );

  // Inputs change just after the rising edge; outputs are sampled on the falling edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall    = 1'b0;
    req_cyc  = '0;
    req_stb  = '0;
    req_we   = '0;
    req_sel  = '0;
    req_adr  = '0;
    req_dat  = '0;
    req_cti  = '0;
    req_bte  = '0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_rty   = 1'b0;
    wb_dat_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_cyc = 2'b11;
    rst = 1'b1;
    #3;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if (wb_cyc !== 1'b0) begin n_bad++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
    n_cmp++; if ({wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, wb_cti, wb_bte} !== '0) begin
      n_bad++; $display("FAIL reset_bus: got adr %h sel %h cti %b want all zero", wb_adr, wb_sel, wb_cti);
    end
    n_cmp++; if ({req_ack, req_err, req_rty} !== 6'b0) begin
      n_bad++; $display("FAIL reset_term: got %b want 000000", {req_ack, req_err, req_rty});
    end
    nxt();
    req_cyc = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single();
    nxt();
    req_cyc = 2'b01; req_stb = 2'b01; req_we = 2'b00;
    req_sel[3:0] = 4'hF; req_adr[31:0] = 32'h100; req_cti[2:0] = CLASSIC;
    smp();
    n_cmp++; if (wb_cyc !== 1'b0) begin n_bad++; $display("FAIL single_req_cycle_cyc: got %b want 0", wb_cyc); end
    nxt(); smp();
    n_cmp++; if (wb_cyc !== 1'b1) begin n_bad++; $display("FAIL single_latency_cyc: got %b want 1", wb_cyc); end
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", grant); end
    n_cmp++; if (wb_adr !== 32'h100) begin n_bad++; $display("FAIL single_adr: got %h want 00000100", wb_adr); end
    n_cmp++; if (req_ack !== 2'b00) begin n_bad++; $display("FAIL single_early_ack: got %b want 00", req_ack); end
    nxt();
    wb_ack = 1'b1; wb_dat_i = 32'hCAFEF00D;
    smp();
    n_cmp++; if (req_ack !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b want 01", req_ack); end
    n_cmp++; if (req_dat_o !== 32'hCAFEF00D) begin n_bad++; $display("FAIL single_rdata: got %h want cafef00d", req_dat_o); end
    nxt();
    wb_ack = 1'b0; req_cyc = 2'b00; req_stb = 2'b00;
    smp();
    n_cmp++; if (wb_cyc !== 1'b0) begin n_bad++; $display("FAIL single_drop_cyc: got %b want 0", wb_cyc); end
    nxt();
    wb_ack = 1'b1;
    smp();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL single_idle_grant: got %b want 00", grant); end
    n_cmp++; if (req_ack !== 2'b00) begin n_bad++; $display("FAIL idle_ack_ignored: got %b want 00", req_ack); end
    nxt();
    wb_ack = 1'b0;
  endtask

  task automatic test_contention();
    rst = 1'b1; #2; rst = 1'b0;
    nxt();
    req_cyc = 2'b11; req_stb = 2'b11;
    smp();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL cont_start_grant: got %b want 00", grant); end
    for (int i = 0; i < 4; i++) begin
      nxt();
      wb_ack = 1'b1;
      smp();
      n_cmp++; if (grant !== exp_order[i]) begin n_bad++; $display("FAIL cont_grant_%0d: got %b want %b", i, grant, exp_order[i]); end
      n_cmp++; if (req_ack !== exp_order[i]) begin n_bad++; $display("FAIL cont_ack_%0d: got %b want %b", i, req_ack, exp_order[i]); end
      nxt();
      wb_ack = 1'b0;
      req_cyc = 2'b11 & ~exp_order[i]; req_stb = req_cyc;
      smp();
      n_cmp++; if (wb_cyc !== 1'b0) begin n_bad++; $display("FAIL cont_drop_%0d: got %b want 0", i, wb_cyc); end
      nxt();
      req_cyc = (i == 3) ? 2'b00 : 2'b11; req_stb = req_cyc;
      smp();
      n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL cont_gap_%0d: got %b want 00", i, grant); end
    end
  endtask

  task automatic test_burst();
    nxt();
    req_cyc = 2'b10; req_stb = 2'b10;
    req_adr[63:32] = beat_adr[0]; req_cti[5:3] = INCR; req_bte[3:2] = LINEAR;
    smp();
    for (int b = 0; b < 4; b++) begin
      nxt();
      req_cyc = 2'b11; req_stb = 2'b11;
      req_adr[63:32] = beat_adr[b]; req_cti[5:3] = beat_cti[b];
      wb_ack = 1'b1;
      smp();
      n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL burst_grant_%0d: got %b want 10", b, grant); end
      n_cmp++; if (wb_cyc !== 1'b1) begin n_bad++; $display("FAIL burst_cyc_%0d: got %b want 1", b, wb_cyc); end
      n_cmp++; if (wb_cti !== beat_cti[b]) begin n_bad++; $display("FAIL burst_cti_%0d: got %b want %b", b, wb_cti, beat_cti[b]); end
      n_cmp++; if (wb_adr !== beat_adr[b]) begin n_bad++; $display("FAIL burst_adr_%0d: got %h want %h", b, wb_adr, beat_adr[b]); end
    end
    nxt();
    wb_ack = 1'b0; req_cyc = 2'b01; req_stb = 2'b01;
    smp();
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL burst_hold_after_eob: got %b want 10", grant); end
    n_cmp++; if (wb_cyc !== 1'b0) begin n_bad++; $display("FAIL burst_release_cyc: got %b want 0", wb_cyc); end
    nxt(); smp();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL burst_gap: got %b want 00", grant); end
    nxt(); smp();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL burst_next_owner: got %b want 01", grant); end
    nxt();
    req_cyc = 2'b00; req_stb = 2'b00;
    nxt();
  endtask

  task automatic test_stall();
    nxt();
    req_cyc = 2'b10; req_stb = 2'b10; req_cti[5:3] = INCR;
    nxt();
    stall = 1'b1; wb_ack = 1'b1;
    smp();
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL stall_inflight_grant: got %b want 10", grant); end
    nxt();
    req_cti[5:3] = EOB;
    smp();
    n_cmp++; if (req_ack !== 2'b10) begin n_bad++; $display("FAIL stall_inflight_ack: got %b want 10", req_ack); end
    nxt();
    wb_ack = 1'b0; req_cyc = 2'b00; req_stb = 2'b00;
    nxt();
    req_cyc = 2'b01; req_stb = 2'b01;
    smp();
    for (int i = 0; i < 2; i++) begin
      nxt(); smp();
      n_cmp++; if (wb_cyc !== 1'b0 || grant !== 2'b00) begin
        n_bad++; $display("FAIL stall_blocked_%0d: got cyc %b grant %b want cyc 0 grant 00", i, wb_cyc, grant);
      end
    end
    nxt();
    stall = 1'b0;
    smp();
    n_cmp++; if (wb_cyc !== 1'b0) begin n_bad++; $display("FAIL stall_release_same_cycle: got %b want 0", wb_cyc); end
    nxt(); smp();
    n_cmp++; if (wb_cyc !== 1'b1 || grant !== 2'b01) begin
      n_bad++; $display("FAIL stall_release_grant: got cyc %b grant %b want cyc 1 grant 01", wb_cyc, grant);
    end
    nxt();
    req_cyc = 2'b00; req_stb = 2'b00;
    nxt();
  endtask

  task automatic test_reset_mid();
    nxt();
    req_cyc = 2'b10; req_stb = 2'b10; req_adr[63:32] = 32'h300;
    nxt(); smp();
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL rstmid_pre_grant: got %b want 10", grant); end
    #1; rst = 1'b1; #1;
    n_cmp++; if (grant !== 2'b00 || wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_adr !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_async: got grant %b cyc %b adr %h want all zero", grant, wb_cyc, wb_adr);
    end
    nxt();
    req_cyc = 2'b11; req_stb = 2'b11;
    #1; rst = 1'b0;
    smp();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rstmid_idle: got %b want 00", grant); end
    nxt(); smp();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rstmid_first_owner: got %b want 01", grant); end
    nxt();
    req_cyc = 2'b00; req_stb = 2'b00;
    nxt();
  endtask

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    nxt();
    req_cyc = 2'b01; req_stb = 2'b01;
    smp();
    for (int c = 1; c <= 8; c++) begin
      nxt(); smp();
      n_cmp++; if (wb_cyc !== 1'b1 || req_err !== 2'b00) begin
        n_bad++; $display("FAIL tmo_wait_%0d: got cyc %b err %b want cyc 1 err 00", c, wb_cyc, req_err);
      end
    end
    nxt(); smp();
    n_cmp++; if (req_err !== 2'b01 || wb_cyc !== 1'b0) begin
      n_bad++; $display("FAIL tmo_pulse: got err %b cyc %b want err 01 cyc 0", req_err, wb_cyc);
    end
    nxt(); smp();
    n_cmp++; if (req_err !== 2'b00 || wb_cyc !== 1'b0) begin
      n_bad++; $display("FAIL tmo_abort: got err %b cyc %b want err 00 cyc 0", req_err, wb_cyc);
    end
    nxt();
    req_cyc = 2'b00; req_stb = 2'b00;
    nxt();
    req_cyc = 2'b10; req_stb = 2'b10;
    smp();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL tmo_idle: got %b want 00", grant); end
    nxt(); smp();
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL tmo_regrant: got %b want 10", grant); end
    nxt();
    req_cyc = 2'b00; req_stb = 2'b00;
    nxt();
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_stall();
    test_reset_mid();
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
